// File: rtl/factor_pkg.sv
// Shared types and helpers for the factorization game judge.
package factor_pkg;

  localparam int unsigned HP_W  = 2;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    J_NONE = 2'b00,
    J_GOOD = 2'b01,
    J_BAD  = 2'b10,
    J_TMO  = 2'b11
  } judg_t;

  typedef enum logic [1:0] {
    R_PLAY  = 2'b00,
    R_CLEAR = 2'b01,
    R_OVER  = 2'b10
  } result_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    SHOW,
    CLEAR,
    OVER
  } state_t;

  // Everything the judge presents to the game join, registered as one word.
  typedef struct packed {
    judg_t             judg;
    result_t           result;
    logic [HP_W-1:0]   hp;
    logic              ok;
    logic [CNT_W-1:0]  correct;
  } judge_out_t;

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Hit points stop at zero instead of wrapping.
  function automatic logic [HP_W-1:0] hp_dec(input logic [HP_W-1:0] hp);
    return (hp == '0) ? '0 : hp - HP_W'(1);
  endfunction

  // Correct-answer count stops at its all-ones value.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/judge_timer.sv
// Shared interval timer: clear, count while enabled, flag the terminal count.
module judge_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic         done_c
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  // High on the final counted cycle; the owner acts on it at the same edge.
  assign done_c = en && (cnt == last);

endmodule

// File: rtl/answer_judge.sv
// Judges answers, tracks hit points / correct count, paces verdict display.
// Optional feature: `ANSWER_TIMEOUT_EN adds a per-question answer time limit.
module answer_judge
  import factor_pkg::*;
#(
  parameter int unsigned HP_INIT   = 3,
  parameter int unsigned CLEAR_CNT = 5,
  parameter int unsigned SHOW_CYC  = 50_000_000,
  parameter int unsigned TMO_CYC   = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       que,
  input  logic [2:0] ans_key,
  input  logic [2:0] sel,
  input  logic       dec,
  output logic [1:0] judg_out,
  output logic [1:0] result_out,
  output logic [1:0] hp_out,
  output logic       ok_out,
  output logic [3:0] correct_out
);

  localparam int unsigned TMR_W = $clog2(umax(SHOW_CYC, TMO_CYC)) + 1;

  state_t     state, nxt;
  judge_out_t out_q, out_d;
  logic       dec_q;
  logic       dec_rise;
  logic       tmr_clr, tmr_en, tmr_done_c;
  logic [TMR_W-1:0] tmr_last;

  assign dec_rise = dec & ~dec_q;

  // Timer restarts on every state change, so each state sees a fresh count.
  assign tmr_clr = (state != nxt);
`ifdef ANSWER_TIMEOUT_EN
  assign tmr_en = (state == SHOW) || (state == WAIT);
`else
  assign tmr_en = (state == SHOW);
`endif
  assign tmr_last = (state == SHOW) ? TMR_W'(SHOW_CYC - 1) : TMR_W'(TMO_CYC - 1);

  judge_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .last   (tmr_last),
    .done_c (tmr_done_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dec_q <= 1'b1;
      out_q <= '{judg: J_NONE, result: R_PLAY, hp: HP_W'(HP_INIT), ok: 1'b0, correct: '0};
    end else begin
      state <= nxt;
      dec_q <= dec;
      out_q <= out_d;
    end
  end

  always_comb begin
    nxt      = state;
    out_d    = out_q;
    out_d.ok = 1'b0;
    case (state)
      IDLE: begin
        if (que) nxt = WAIT;
      end
      WAIT: begin
        // A withdrawn question wins over a simultaneous press.
        if (!que) begin
          nxt = IDLE;
        end else if (dec_rise) begin
          nxt = SHOW;
          if (sel == ans_key) begin
            out_d.judg    = J_GOOD;
            out_d.correct = cnt_inc(out_q.correct);
          end else begin
            out_d.judg = J_BAD;
            out_d.hp   = hp_dec(out_q.hp);
          end
        end
`ifdef ANSWER_TIMEOUT_EN
        else if (tmr_done_c) begin
          nxt        = SHOW;
          out_d.judg = J_TMO;
          out_d.hp   = hp_dec(out_q.hp);
        end
`endif
      end
      SHOW: begin
        if (tmr_done_c) begin
          out_d.judg = J_NONE;
          if (out_q.correct == CNT_W'(CLEAR_CNT)) begin
            nxt          = CLEAR;
            out_d.result = R_CLEAR;
          end else if (out_q.hp == '0) begin
            nxt          = OVER;
            out_d.result = R_OVER;
          end else begin
            nxt      = IDLE;
            out_d.ok = 1'b1;
          end
        end
      end
      CLEAR, OVER: begin
        nxt = state;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  assign judg_out    = out_q.judg;
  assign result_out  = out_q.result;
  assign hp_out      = out_q.hp;
  assign ok_out      = out_q.ok;
  assign correct_out = out_q.correct;

endmodule

// File: tb/tb_answer_judge.sv
// Bench for answer_judge: vector table, directed corner sequences, random vs. model.
module tb_answer_judge;

  localparam int unsigned SHOW = 4;
  localparam int unsigned TMO  = 10;
  localparam int unsigned HPI  = 3;
  localparam int unsigned CLR  = 2;

  logic       clk = 1'b0;
  logic       rst, que, dec;
  logic [2:0] ans_key, sel;
  logic [1:0] judg_out, result_out, hp_out;
  logic       ok_out;
  logic [3:0] correct_out;

  always #5 clk = ~clk;

  answer_judge #(
    .HP_INIT   (HPI),
    .CLEAR_CNT (CLR),
    .SHOW_CYC  (SHOW),
    .TMO_CYC   (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .que         (que),
    .ans_key     (ans_key),
    .sel         (sel),
    .dec         (dec),
    .judg_out    (judg_out),
    .result_out  (result_out),
    .hp_out      (hp_out),
    .ok_out      (ok_out),
    .correct_out (correct_out)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  string ctx     = "init";

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0d, want %0d (t=%0t)", ctx, name, act, exp, $time);
    end
  endtask

  // Game model: question flag, display countdown, answer age, terminal flag.
  int m_hp, m_cor, m_res, m_judg, m_ok, m_show, m_age;
  bit m_inq, m_done, m_decp;

  task automatic model_step(input bit r, input bit q, input int k, input int s, input bit d);
    bit rise;
    if (r) begin
      m_hp = HPI; m_cor = 0; m_res = 0; m_judg = 0; m_ok = 0;
      m_show = 0; m_age = 0; m_inq = 0; m_done = 0; m_decp = 1;
      return;
    end
    rise   = d && !m_decp;
    m_decp = d;
    m_ok   = 0;
    if (m_done) begin
      m_ok = 0;
    end else if (m_show > 0) begin
      m_show--;
      if (m_show == 0) begin
        m_judg = 0;
        if (m_cor == CLR) begin m_res = 1; m_done = 1; end
        else if (m_hp == 0) begin m_res = 2; m_done = 1; end
        else begin m_ok = 1; m_inq = 0; end
      end
    end else if (!m_inq) begin
      if (q) begin m_inq = 1; m_age = 0; end
    end else if (!q) begin
      m_inq = 0;
    end else if (rise) begin
      if (s == k) begin m_judg = 1; m_cor = (m_cor < 15) ? m_cor + 1 : 15; end
      else begin m_judg = 2; m_hp = (m_hp > 0) ? m_hp - 1 : 0; end
      m_show = SHOW;
    end else begin
      m_age++;
`ifdef ANSWER_TIMEOUT_EN
      if (m_age == TMO) begin
        m_judg = 3; m_hp = (m_hp > 0) ? m_hp - 1 : 0; m_show = SHOW;
      end
`endif
    end
  endtask

  task automatic drive_clk(input bit r, input bit q, input int k, input int s, input bit d);
    rst = r; que = q; ans_key = 3'(k); sel = 3'(s); dec = d;
    @(posedge clk);
    model_step(r, q, k, s, d);
    #1;
  endtask

  task automatic step(input bit r, input bit q, input int k, input int s, input bit d);
    drive_clk(r, q, k, s, d);
    chk("judg",    int'(judg_out),    m_judg);
    chk("result",  int'(result_out),  m_res);
    chk("hp",      int'(hp_out),      m_hp);
    chk("ok",      int'(ok_out),      m_ok);
    chk("correct", int'(correct_out), m_cor);
  endtask

  // From IDLE: load a question, answer with s (key 3), sit out the display.
  task automatic play(input int s);
    step(0, 1, 3, s, 0);
    step(0, 1, 3, s, 1);
    repeat (SHOW) step(0, 1, 3, s, 0);
  endtask

  typedef struct {
    bit q; int k; int s; bit d;
    int judg; int res; int hp; bit ok; int cor;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit q, input int k, input int s, input bit d,
                     input int judg, input int res, input int hp, input bit ok, input int cor);
    vec_t v;
    v = '{q: q, k: k, s: s, d: d, judg: judg, res: res, hp: hp, ok: ok, cor: cor};
    tbl.push_back(v);
  endtask

  initial begin
    int tmo_at;
    int tmo_hp;
    bit q_r, d_r;
    int k_r, s_r;

    // Reset state
    ctx = "reset";
    step(1, 0, 0, 0, 0);
    chk("judg0",    int'(judg_out),    0);
    chk("result0",  int'(result_out),  0);
    chk("hp0",      int'(hp_out),      3);
    chk("ok0",      int'(ok_out),      0);
    chk("correct0", int'(correct_out), 0);

    // Vector table: good answer, bad answer, good answer -> clear
    ctx = "table";
    add(1, 3, 3, 0,  0, 0, 3, 0, 0);
    add(1, 3, 3, 1,  1, 0, 3, 0, 1);
    add(1, 3, 3, 1,  1, 0, 3, 0, 1);
    add(1, 3, 3, 0,  1, 0, 3, 0, 1);
    add(1, 3, 3, 0,  1, 0, 3, 0, 1);
    add(1, 3, 3, 0,  0, 0, 3, 1, 1);
    add(1, 3, 5, 0,  0, 0, 3, 0, 1);
    add(1, 3, 5, 1,  2, 0, 2, 0, 1);
    add(1, 3, 5, 0,  2, 0, 2, 0, 1);
    add(1, 3, 5, 0,  2, 0, 2, 0, 1);
    add(1, 3, 5, 0,  2, 0, 2, 0, 1);
    add(1, 3, 5, 0,  0, 0, 2, 1, 1);
    add(1, 3, 3, 0,  0, 0, 2, 0, 1);
    add(1, 3, 3, 1,  1, 0, 2, 0, 2);
    add(1, 3, 3, 0,  1, 0, 2, 0, 2);
    add(1, 3, 3, 0,  1, 0, 2, 0, 2);
    add(1, 3, 3, 0,  1, 0, 2, 0, 2);
    add(1, 3, 3, 0,  0, 1, 2, 0, 2);
    add(1, 3, 3, 1,  0, 1, 2, 0, 2);
    add(0, 3, 3, 0,  0, 1, 2, 0, 2);
    foreach (tbl[i]) begin
      drive_clk(0, tbl[i].q, tbl[i].k, tbl[i].s, tbl[i].d);
      chk($sformatf("v%0d_judg", i),    int'(judg_out),    tbl[i].judg);
      chk($sformatf("v%0d_result", i),  int'(result_out),  tbl[i].res);
      chk($sformatf("v%0d_hp", i),      int'(hp_out),      tbl[i].hp);
      chk($sformatf("v%0d_ok", i),      int'(ok_out),      int'(tbl[i].ok));
      chk($sformatf("v%0d_correct", i), int'(correct_out), tbl[i].cor);
    end

    // Three wrong answers -> game over, then presses ignored
    ctx = "over";
    step(1, 0, 0, 0, 0);
    for (int n = 0; n < 3; n++) begin
      step(0, 1, 3, 5, 0);
      step(0, 1, 3, 5, 1);
      chk("bad_judg", int'(judg_out), 2);
      chk("bad_hp",   int'(hp_out),   2 - n);
      repeat (SHOW) step(0, 1, 3, 5, 0);
      chk("bad_ok", int'(ok_out), (n < 2) ? 1 : 0);
    end
    chk("over_result", int'(result_out), 2);
    repeat (3) begin
      step(0, 1, 3, 3, 1);
      step(0, 1, 3, 3, 0);
      chk("over_judg", int'(judg_out),   0);
      chk("over_hold", int'(result_out), 2);
    end

    // Two correct answers -> clear with full hit points
    ctx = "clear";
    step(1, 0, 0, 0, 0);
    play(3);
    play(3);
    chk("clr_result",  int'(result_out),  1);
    chk("clr_hp",      int'(hp_out),      3);
    chk("clr_correct", int'(correct_out), 2);

    // Button held through reset, press during display, question withdrawn
    ctx = "corner";
    step(1, 0, 3, 3, 1);
    step(1, 1, 3, 3, 1);
    repeat (5) begin
      step(0, 1, 3, 3, 1);
      chk("held_judg", int'(judg_out), 0);
    end
    step(0, 1, 3, 5, 0);
    step(0, 1, 3, 5, 1);
    chk("c_judg", int'(judg_out), 2);
    step(0, 1, 3, 3, 0);
    step(0, 1, 3, 3, 1);
    step(0, 1, 3, 3, 0);
    chk("show_dec_judg", int'(judg_out), 2);
    chk("show_dec_hp",   int'(hp_out),   2);
    step(0, 1, 3, 3, 0);
    chk("c_ok", int'(ok_out), 1);
    step(0, 1, 3, 3, 0);
    step(0, 0, 3, 3, 0);
    step(0, 0, 3, 3, 1);
    chk("noque_judg", int'(judg_out), 0);
    step(0, 0, 3, 3, 0);
    step(0, 1, 3, 3, 0);
    step(0, 0, 3, 3, 1);
    chk("drop_judg",    int'(judg_out),    0);
    chk("drop_correct", int'(correct_out), 0);
    step(0, 1, 3, 3, 1);
    chk("drop_idle_judg", int'(judg_out), 0);

    // Reset in the middle of a display
    ctx = "midrst";
    step(1, 0, 0, 0, 0);
    step(0, 1, 3, 3, 0);
    step(0, 1, 3, 3, 1);
    step(0, 1, 3, 3, 0);
    step(1, 1, 3, 3, 0);
    chk("r_judg",    int'(judg_out),    0);
    chk("r_result",  int'(result_out),  0);
    chk("r_hp",      int'(hp_out),      3);
    chk("r_ok",      int'(ok_out),      0);
    chk("r_correct", int'(correct_out), 0);

    // Idle player: timeout only when the feature is built in
    ctx = "timeout";
    step(1, 0, 0, 0, 0);
    tmo_at = -1;
    tmo_hp = -1;
    for (int c = 1; c <= 100; c++) begin
      step(0, 1, 3, 3, 0);
      if (tmo_at < 0 && judg_out == 2'd3) begin
        tmo_at = c;
        tmo_hp = int'(hp_out);
      end
    end
`ifdef ANSWER_TIMEOUT_EN
    chk("tmo_cycle", tmo_at, int'(TMO) + 1);
    chk("tmo_hp",    tmo_hp, 2);
`else
    chk("tmo_cycle", tmo_at, -1);
    chk("tmo_judg",  int'(judg_out), 0);
`endif

    // Random play against the model
    ctx = "random";
    step(1, 0, 0, 0, 0);
    q_r = 0; d_r = 0; k_r = 0; s_r = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(39) == 0) q_r = !q_r;
      if (!q_r) k_r = int'($urandom_range(7));
      s_r = ($urandom_range(1) == 0) ? k_r : int'($urandom_range(7));
      if ($urandom_range(3) == 0) d_r = !d_r;
      step($urandom_range(59) == 0, q_r, k_r, s_r, d_r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
